subleq_input_fifo: RTL
======================

Name: subleq_input_fifo

Overview:
- Input stage directly upstream of the SUBLEQ system's MMIO input port.
- Buffers words from a streaming source (valid/ready plus last flag) in a circular FIFO.
- Answers the circuit's four-phase input request (in_req/in_ack/in_data/in_eof).
- Signals end-of-file once the source has ended and the buffer has drained.

Parameters:
- DEPTH, 16, FIFO capacity in words. Power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width. Derived; never overridden.

Ports:
- clk  input  1  system clock; rising edge.
- areset  input  1  asynchronous reset, active-low (0 = reset).
- src_valid  input  1  source word valid.
- src_ready  output  1  FIFO accepts a word this cycle.
- src_data  input  `WORD_SIZE  source word.
- src_last  input  1  qualifies src_data as the final word of the stream.
- in_req  input  1  circuit requests one input word; held until acknowledged.
- in_ack  output  1  one-cycle acknowledge pulse.
- in_data  output  `WORD_SIZE  word delivered; valid while in_ack=1.
- in_eof  output  1  with in_ack: no data remains.
- level  output  PTR_W+1  fill count. Present only with SUBLEQ_IN_LEVEL_EN.

Behaviour:
- Reset (areset=0, asynchronous):
  - src_ready=0, in_ack=0, in_eof=0, in_data=0.
  - Pointers and count cleared; eof_seen=0; state=IDLE.
  - Reset mid-transaction discards buffered data and any pending ack.
- Push:
  - src_ready is registered. It is 1 when count<DEPTH and eof_seen=0.
  - A word is written when src_valid and src_ready are both 1. Write pointer wraps modulo DEPTH.
  - If src_last=1 with an accepted word, eof_seen is set. The word itself is stored normally.
  - Once eof_seen=1, src_ready stays 0 until reset.
- Consumer FSM, states IDLE, ACK, RELEASE:
  - IDLE, in_req=1, count>0: pop head into in_data register; go to ACK with in_ack=1, in_eof=0. The ack appears one cycle after in_req is sampled.
  - IDLE, in_req=1, count=0, eof_seen=1: go to ACK with in_ack=1, in_eof=1, in_data=0.
  - IDLE, in_req=1, count=0, eof_seen=0: stay in IDLE and wait. No timeout.
  - ACK: in_ack and in_eof drop next cycle; go to RELEASE. in_data holds its value.
  - RELEASE: wait until in_req=0, then go to IDLE. A request held high never produces a second ack.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- When full, src_ready stays 0 in the pop cycle; space reappears on the following cycle.
- Empty with a push landing in the same cycle as in_req: the word is visible to the FSM on the next cycle. Maximum latency from push to ack is 2 cycles.
- in_eof is sticky per request: every request after drain-with-eof returns in_ack with in_eof=1.
- Count never exceeds DEPTH. Overflow and underflow are impossible by construction; the verifier asserts this.

Optional Feature:
- Macro: SUBLEQ_IN_LEVEL_EN.
- Defined: the level port exists and equals the current count, registered and updated in the same cycle as the pointers.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared defines.vh:
  - `WORD_SIZE (existing).
  - FSM state encodings: SUBLEQ_IN_IDLE=2'd0, SUBLEQ_IN_ACK=2'd1, SUBLEQ_IN_RELEASE=2'd2.
- One natural sub-module: subleq_fifo_ram. It holds DEPTH x `WORD_SIZE storage with a synchronous write port and a combinational read port.
- Pointer, count and FSM logic stay in the top block.

Test Plan:
- Reset then push 0x0005, 0x0007(last); in_req three times -> acks with in_data 0x0005, 0x0007, then in_eof=1; src_ready=0 after the last word.
- DEPTH=4: push 6 words with src_valid held -> exactly 4 accepted, src_ready=0. One request/ack -> src_ready=1 a cycle later and the 5th word is accepted.
- in_req with FIFO empty and no eof for 20 cycles -> in_ack stays 0. Push 0x00AB -> in_ack=1 with 0x00AB within 2 cycles.
- in_req held high for 10 cycles after ack -> exactly one in_ack pulse. Drop and reassert -> second ack.
- Simultaneous push and pop at count=2 -> count stays 2 (level=2 with SUBLEQ_IN_LEVEL_EN); FIFO order preserved across pointer wrap.
- areset=0 asserted during the ACK cycle with 3 words buffered -> in_ack=0 immediately. After release, in_req waits (empty, no eof).

Source files
------------

// File: rtl/subleq_input_fifo_pkg.sv
// Shared word width and consumer handshake state encodings for the SUBLEQ input stage.
// Pure declarations: no latency, no backpressure.
package subleq_input_fifo_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    SUBLEQ_IN_IDLE    = 2'd0,
    SUBLEQ_IN_ACK     = 2'd1,
    SUBLEQ_IN_RELEASE = 2'd2
  } in_state_e;

endpackage

// File: rtl/subleq_fifo_ram.sv
// DEPTH x WORD_SIZE word store: synchronous write, combinational read.
// Read data follows raddr in the same cycle; no backpressure (the caller owns full/empty).
module subleq_fifo_ram
  import subleq_input_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_W-1:0]     waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [PTR_W-1:0]     raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/subleq_input_fifo.sv
// Stream-to-MMIO input buffer: circular FIFO answering a four-phase in_req/in_ack handshake (optional level port: SUBLEQ_IN_LEVEL_EN).
// Ack one cycle after in_req is sampled with data present; push-to-ack at most 2 cycles.
// src_ready is registered: low when full or once the last word has been taken; held-high in_req acks once.
module subleq_input_fifo
  import subleq_input_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [WORD_SIZE-1:0] src_data,
  input  logic                 src_last,
  input  logic                 in_req,
  output logic                 in_ack,
  output logic [WORD_SIZE-1:0] in_data,
  output logic                 in_eof
`ifdef SUBLEQ_IN_LEVEL_EN
  ,
  output logic [PTR_W:0]       level
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       count_next;
  logic                 eof_seen;
  logic                 eof_seen_next;
  logic                 eof_r;
  logic                 push;
  logic                 pop;
  logic                 eof_take;
  logic [WORD_SIZE-1:0] head;
  in_state_e            state;
  in_state_e            state_next;

  subleq_fifo_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (src_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign push          = src_valid & src_ready;
  assign eof_seen_next = eof_seen | (push & src_last);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // src_ready looks ahead at this cycle's push/pop so a registered ready can never overfill.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      eof_seen  <= 1'b0;
      src_ready <= 1'b0;
      in_data   <= '0;
      eof_r     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_next;
      eof_seen  <= eof_seen_next;
      src_ready <= (count_next < FULL_CNT) && !eof_seen_next;
      if (pop) begin
        in_data <= head;
        eof_r   <= 1'b0;
      end else if (eof_take) begin
        in_data <= '0;
        eof_r   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= SUBLEQ_IN_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    eof_take   = 1'b0;
    case (state)
      SUBLEQ_IN_IDLE: begin
        if (in_req) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = SUBLEQ_IN_ACK;
          end else if (eof_seen) begin
            eof_take   = 1'b1;
            state_next = SUBLEQ_IN_ACK;
          end
        end
      end
      SUBLEQ_IN_ACK: begin
        state_next = SUBLEQ_IN_RELEASE;
      end
      SUBLEQ_IN_RELEASE: begin
        if (!in_req) begin
          state_next = SUBLEQ_IN_IDLE;
        end
      end
      default: begin
        state_next = SUBLEQ_IN_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ack = (state == SUBLEQ_IN_ACK);
    in_eof = in_ack & eof_r;
  end

`ifdef SUBLEQ_IN_LEVEL_EN
  assign level = count;
`endif

endmodule
